// File: rtl/trace_log_buffer_pkg.sv
// trace_log_buffer shared definitions:
// bus field widths, register address, read FSM states.
package trace_log_buffer_pkg;

  localparam int LOG_LOG_DEPTH = 4;
  localparam logic [31:0] DEBUG_CAPACITY = 32'h0000_0010;

  localparam int PCI_DATA_W = 512;
  localparam int PCI_LEN_W  = 8;
  localparam int PCI_ADDR_W = 64;
  localparam int PCI_RESP_W = 2;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_t;

endpackage

// File: rtl/trace_log_ram.sv
// trace_log_ram: simple dual-port RAM,
// one write port, one registered read port.
module trace_log_ram #(
  parameter int W  = 256,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);

  localparam int N = 1 << AW;

  logic [W-1:0] mem [N];

  // write port; read returns the new word on an address collision
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && waddr == raddr) q <= wdata;
    else q <= mem[raddr];
  end

endmodule

// File: rtl/trace_log_buffer.sv
// trace_log_buffer: circular trace capture FIFO
// drained through a simplified AXI read channel.
module trace_log_buffer
  import trace_log_buffer_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int LOG_DEPTH = 10,
  parameter int ID_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wvalid,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pci_arvalid,
  output logic                  pci_arready,
  input  logic [ID_W-1:0]       pci_arid,
  input  logic [PCI_LEN_W-1:0]  pci_arlen,
  input  logic [PCI_ADDR_W-1:0] pci_araddr,
  output logic                  pci_rvalid,
  input  logic                  pci_rready,
  output logic [PCI_DATA_W-1:0] pci_rdata,
  output logic [ID_W-1:0]       pci_rid,
  output logic                  pci_rlast,
  output logic [PCI_RESP_W-1:0] pci_rresp,
  output logic [LOG_DEPTH:0]    size,
  output logic                  overflow
);

  localparam logic [LOG_DEPTH:0] FULL =
    {1'b1, {LOG_DEPTH{1'b0}}};

  rd_state_t            state;
  logic [LOG_DEPTH-1:0] head;
  logic [LOG_DEPTH-1:0] tail;
  logic [LOG_DEPTH-1:0] head_next;
  logic [8:0]           beats_left;
  logic [WIDTH-1:0]     q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 unused_addr;

  assign unused_addr = ^pci_araddr;
  assign pci_rresp   = '0;

  assign full  = (size == FULL);
  assign empty = (size == '0);
  assign push  = wvalid && !full;
  assign pop   = pci_rvalid && pci_rready && !empty;

  // RAM is always read at next head so the head word is ready
  assign head_next = pop ? head + LOG_DEPTH'(1) : head;

  trace_log_ram #(
    .W  (WIDTH),
    .AW (LOG_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head_next),
    .q     (q)
  );

  // pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      size     <= '0;
      overflow <= 1'b0;
    end else begin
      head <= head_next;
      if (push) tail <= tail + LOG_DEPTH'(1);
      if (push && !pop) size <= size + 1'b1;
      else if (!push && pop) size <= size - 1'b1;
      if (wvalid && full) overflow <= 1'b1;
    end
  end

  // read burst FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= R_IDLE;
      pci_arready <= 1'b1;
      pci_rvalid  <= 1'b0;
      pci_rlast   <= 1'b0;
      pci_rid     <= '0;
      beats_left  <= '0;
    end else begin
      unique case (state)
        R_IDLE: begin
          if (pci_arvalid) begin
            state       <= R_BURST;
            pci_arready <= 1'b0;
            pci_rvalid  <= 1'b1;
            pci_rid     <= pci_arid;
            beats_left  <= {1'b0, pci_arlen} + 9'd1;
            pci_rlast   <= (pci_arlen == '0);
          end
        end
        R_BURST: begin
          if (pci_rready) begin
            if (beats_left == 9'd1) begin
              state       <= R_IDLE;
              pci_arready <= 1'b1;
              pci_rvalid  <= 1'b0;
              pci_rlast   <= 1'b0;
            end else begin
              beats_left <= beats_left - 9'd1;
              pci_rlast  <= (beats_left == 9'd2);
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  // beat data: head entry, or zero when nothing is stored
  always_comb begin
    pci_rdata = '0;
    if (pci_rvalid && !empty) pci_rdata[WIDTH-1:0] = q;
  end

endmodule

// File: tb/tb_trace_log_buffer.sv
// tb_trace_log_buffer: directed stimulus with a
// beat scoreboard checked by a separate monitor.
module tb_trace_log_buffer;

  localparam int W  = 16;
  localparam int LD = 2;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wvalid = 1'b0;
  logic [W-1:0]   wdata = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IW-1:0]  arid = '0;
  logic [7:0]     arlen = '0;
  logic [63:0]    araddr = '0;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [511:0]   rdata;
  logic [IW-1:0]  rid;
  logic           rlast;
  logic [1:0]     rresp;
  logic [LD:0]    size;
  logic           overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  beat_t sbq[$];

  trace_log_buffer #(
    .WIDTH     (W),
    .LOG_DEPTH (LD),
    .ID_W      (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wvalid      (wvalid),
    .wdata       (wdata),
    .pci_arvalid (arvalid),
    .pci_arready (arready),
    .pci_arid    (arid),
    .pci_arlen   (arlen),
    .pci_araddr  (araddr),
    .pci_rvalid  (rvalid),
    .pci_rready  (rready),
    .pci_rdata   (rdata),
    .pci_rid     (rid),
    .pci_rlast   (rlast),
    .pci_rresp   (rresp),
    .size        (size),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      wdata  = W'(first + i);
      tick();
    end
    wvalid = 1'b0;
  endtask

  task automatic exp_beat(input int d,
                          input logic last,
                          input logic [IW-1:0] id);
    beat_t b;
    b.data = W'(d);
    b.last = last;
    b.id   = id;
    sbq.push_back(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rready = 1'b1;
    while (sbq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain timeout: %0d beats left, want 0",
               sbq.size());
      sbq.delete();
    end
    rready = 1'b0;
  endtask

  task automatic burst(input logic [IW-1:0] id,
                       input logic [7:0] len,
                       input int stall);
    logic [511:0] hold;
    arvalid = 1'b1;
    arid    = id;
    arlen   = len;
    tick();
    arvalid = 1'b0;
    chk("arready_busy", 512'(arready), 512'(1'b0));
    chk("rvalid_first", 512'(rvalid), 512'(1'b1));
    hold = 512'(sbq[0].data);
    for (int i = 0; i < stall; i++) begin
      chk("stall_rvalid", 512'(rvalid), 512'(1'b1));
      chk("stall_rdata", rdata, hold);
      chk("stall_size", 512'(size), 512'(3));
      tick();
    end
    drain();
    chk("rvalid_end", 512'(rvalid), 512'(1'b0));
    tick();
    chk("arready_end", 512'(arready), 512'(1'b1));
  endtask

  // monitor: compare every accepted beat against the queue
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && rvalid && rready) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected beat: rdata %0h, none expected",
                 rdata);
      end else begin
        e = sbq.pop_front();
        chk("rdata", rdata, 512'(e.data));
        chk("rlast", 512'(rlast), 512'(e.last));
        chk("rid", 512'(rid), 512'(e.id));
        chk("rresp", 512'(rresp), 512'(0));
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_size", 512'(size), 512'(0));
    chk("rst_ovf", 512'(overflow), 512'(0));
    chk("rst_arready", 512'(arready), 512'(1));
    chk("rst_rvalid", 512'(rvalid), 512'(0));
    chk("rst_rlast", 512'(rlast), 512'(0));
    chk("rst_rdata", rdata, 512'(0));

    // three words, one burst of three
    write_seq('hA, 3);
    chk("t1_size", 512'(size), 512'(3));
    exp_beat('hA, 1'b0, 4'd5);
    exp_beat('hB, 1'b0, 4'd5);
    exp_beat('hC, 1'b1, 4'd5);
    burst(4'd5, 8'd2, 0);
    chk("t1_size_end", 512'(size), 512'(0));

    // overflow at depth 4
    do_reset();
    write_seq(1, 6);
    chk("t2_size", 512'(size), 512'(4));
    chk("t2_ovf", 512'(overflow), 512'(1));
    exp_beat(1, 1'b0, 4'd3);
    exp_beat(2, 1'b0, 4'd3);
    exp_beat(3, 1'b0, 4'd3);
    exp_beat(4, 1'b1, 4'd3);
    burst(4'd3, 8'd3, 0);
    chk("t2_size_end", 512'(size), 512'(0));
    chk("t2_ovf_sticky", 512'(overflow), 512'(1));

    // empty FIFO returns zero beats
    exp_beat(0, 1'b0, 4'd9);
    exp_beat(0, 1'b1, 4'd9);
    burst(4'd9, 8'd1, 0);
    chk("t3_size", 512'(size), 512'(0));

    // back-pressure for five cycles
    write_seq(7, 3);
    exp_beat(7, 1'b0, 4'd1);
    exp_beat(8, 1'b0, 4'd1);
    exp_beat(9, 1'b1, 4'd1);
    burst(4'd1, 8'd2, 5);
    chk("t4_size_end", 512'(size), 512'(0));

    // full FIFO: concurrent write dropped, pop happens
    do_reset();
    write_seq('h20, 4);
    chk("t5_size_full", 512'(size), 512'(4));
    chk("t5_ovf_clear", 512'(overflow), 512'(0));
    exp_beat('h20, 1'b1, 4'd2);
    arvalid = 1'b1;
    arid    = 4'd2;
    arlen   = 8'd0;
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    wvalid  = 1'b1;
    wdata   = W'('h99);
    tick();
    rready = 1'b0;
    wvalid = 1'b0;
    chk("t5_size", 512'(size), 512'(3));
    chk("t5_ovf", 512'(overflow), 512'(1));
    chk("t5_rvalid", 512'(rvalid), 512'(0));
    tick();
    exp_beat('h21, 1'b0, 4'd6);
    exp_beat('h22, 1'b0, 4'd6);
    exp_beat('h23, 1'b1, 4'd6);
    burst(4'd6, 8'd2, 0);
    chk("t5_size_end", 512'(size), 512'(0));

    // reset in the middle of a four-beat burst
    write_seq('h30, 4);
    exp_beat('h30, 1'b0, 4'd7);
    arvalid = 1'b1;
    arid    = 4'd7;
    arlen   = 8'd3;
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    tick();
    rready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rvalid", 512'(rvalid), 512'(0));
    chk("t6_size", 512'(size), 512'(0));
    chk("t6_rdata", rdata, 512'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("t6_arready", 512'(arready), 512'(1));
    chk("t6_ovf", 512'(overflow), 512'(0));
    exp_beat(0, 1'b0, 4'd4);
    exp_beat(0, 1'b1, 4'd4);
    burst(4'd4, 8'd1, 0);
    chk("t6_size_end", 512'(size), 512'(0));

    tick();
    chk("sb_empty", 512'(sbq.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
